// File: rtl/timer_rx_pkg.sv
// Shared types and helpers for the timer stream receiver.
// State encoding, default data width and a width-generic saturating increment.
package timer_pkg;

   localparam int DEF_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   // Saturates at the all-ones value of a w-bit field (w < 32); callers cast back down.
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
      logic [31:0] top;
      top = (32'd1 << w) - 32'd1;
      return (v >= top) ? top : v + 32'd1;
   endfunction

endpackage

// File: rtl/timer_rx_if.sv
// Timer sample stream plus snapshot valid/ready channel between a driver and timer_rx.
// master = stimulus/consumer side, slave = the receiver.
interface timer_rx_if #(
   parameter int WIDTH  = 16,
   parameter int CNT_W  = 16,
   parameter int WRAP_W = 8,
   parameter int ERR_W  = 8
);
   logic              t_valid;
   logic [WIDTH-1:0]  t_out;
   logic              snap_req;
   logic              snap_ready;
   logic              snap_valid;
   logic [WIDTH-1:0]  snap_last;
   logic [CNT_W-1:0]  snap_samples;
   logic [WRAP_W-1:0] snap_wraps;
   logic [ERR_W-1:0]  snap_errs;

   modport master (
      output t_valid, t_out, snap_req, snap_ready,
      input  snap_valid, snap_last, snap_samples, snap_wraps, snap_errs
   );

   modport slave (
      input  t_valid, t_out, snap_req, snap_ready,
      output snap_valid, snap_last, snap_samples, snap_wraps, snap_errs
   );
endinterface

// File: rtl/timer_rx_snap.sv
// Snapshot holding registers: capture on req while empty, valid one cycle later.
// Fields stay frozen while valid; valid drops the cycle after valid && ready.
module timer_rx_snap #(
   parameter int WIDTH  = 16,
   parameter int CNT_W  = 16,
   parameter int WRAP_W = 8,
   parameter int ERR_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              ready,
   input  logic [WIDTH-1:0]  last,
   input  logic [CNT_W-1:0]  samples,
   input  logic [WRAP_W-1:0] wraps,
   input  logic [ERR_W-1:0]  errs,
   output logic              valid,
   output logic [WIDTH-1:0]  s_last,
   output logic [CNT_W-1:0]  s_samples,
   output logic [WRAP_W-1:0] s_wraps,
   output logic [ERR_W-1:0]  s_errs
);

   always_ff @(posedge clk) begin
      if (rst) begin
         valid     <= 1'b0;
         s_last    <= '0;
         s_samples <= '0;
         s_wraps   <= '0;
         s_errs    <= '0;
      end else if (valid && ready) begin
         // A request landing on the accept cycle is dropped; requester re-pulses.
         valid <= 1'b0;
      end else if (req && !valid) begin
         valid     <= 1'b1;
         s_last    <= last;
         s_samples <= samples;
         s_wraps   <= wraps;
         s_errs    <= errs;
      end
   end

endmodule

// File: rtl/timer_rx.sv
// Checks a timer stream for strict +1 sequencing, counts samples/wraps/errors, raises sticky flags.
// Flags and counters update one cycle after the sample; snapshot readout via timer_rx_snap.
module timer_rx
   import timer_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int CNT_W     = 16,
   parameter int WRAP_W    = 8,
   parameter int ERR_W     = 8,
   parameter int ERR_LIMIT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [WIDTH-1:0] thresh,
   timer_rx_if.slave        bus,
   output logic             seq_err,
   output logic             alarm,
   output logic             fault
);

   state_t            state, state_n;
   logic [WIDTH-1:0]  last, last_n;
   logic [WIDTH-1:0]  expected, expected_n;
   logic [CNT_W-1:0]  samples, samples_n;
   logic [WRAP_W-1:0] wraps, wraps_n;
   logic [ERR_W-1:0]  errs, errs_n;
   logic              seq_err_n, alarm_n;
   logic              hit;

   assign hit = (thresh != '0) && (bus.t_out >= thresh);

   always_comb begin
      state_n    = state;
      last_n     = last;
      expected_n = expected;
      samples_n  = samples;
      wraps_n    = wraps;
      errs_n     = errs;
      seq_err_n  = seq_err;
      alarm_n    = alarm;

      if (clr) begin
         state_n    = IDLE;
         last_n     = '0;
         expected_n = '0;
         samples_n  = '0;
         wraps_n    = '0;
         errs_n     = '0;
         seq_err_n  = 1'b0;
         alarm_n    = 1'b0;
      end else if (bus.t_valid) begin
         case (state)
            IDLE: begin
               last_n     = bus.t_out;
               expected_n = bus.t_out + 1'b1;
               samples_n  = CNT_W'(1);
               state_n    = TRACK;
               if (hit) alarm_n = 1'b1;
            end
            TRACK: begin
               samples_n  = CNT_W'(sat_inc(32'(samples), CNT_W));
               last_n     = bus.t_out;
               expected_n = bus.t_out + 1'b1;
               if (bus.t_out == expected) begin
                  if (bus.t_out == '0) wraps_n = WRAP_W'(sat_inc(32'(wraps), WRAP_W));
               end else begin
                  errs_n    = ERR_W'(sat_inc(32'(errs), ERR_W));
                  seq_err_n = 1'b1;
                  if (errs_n >= ERR_W'(ERR_LIMIT)) state_n = FAULT;
               end
               if (hit) alarm_n = 1'b1;
            end
            FAULT: begin
               samples_n = CNT_W'(sat_inc(32'(samples), CNT_W));
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last     <= '0;
         expected <= '0;
         samples  <= '0;
         wraps    <= '0;
         errs     <= '0;
         seq_err  <= 1'b0;
         alarm    <= 1'b0;
      end else begin
         state    <= state_n;
         last     <= last_n;
         expected <= expected_n;
         samples  <= samples_n;
         wraps    <= wraps_n;
         errs     <= errs_n;
         seq_err  <= seq_err_n;
         alarm    <= alarm_n;
      end
   end

   assign fault = (state == FAULT);

   timer_rx_snap #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W),
      .WRAP_W(WRAP_W),
      .ERR_W (ERR_W)
   ) u_snap (
      .clk      (clk),
      .rst      (rst),
      .req      (bus.snap_req),
      .ready    (bus.snap_ready),
      .last     (last),
      .samples  (samples),
      .wraps    (wraps),
      .errs     (errs),
      .valid    (bus.snap_valid),
      .s_last   (bus.snap_last),
      .s_samples(bus.snap_samples),
      .s_wraps  (bus.snap_wraps),
      .s_errs   (bus.snap_errs)
   );

endmodule

// File: tb/tb_timer_rx.sv
// Directed plus random stimulus for timer_rx, checked every cycle against a sequence-rule model.
module tb_timer_rx;

   logic        clk = 1'b0;
   logic        rst, clr;
   logic [15:0] thresh;
   logic        seq_err, alarm, fault;

   always #5 clk = ~clk;

   timer_rx_if #(.WIDTH(16), .CNT_W(16), .WRAP_W(8), .ERR_W(8)) bus ();

   timer_rx #(.WIDTH(16), .CNT_W(16), .WRAP_W(8), .ERR_W(8), .ERR_LIMIT(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .thresh (thresh),
      .bus    (bus.slave),
      .seq_err(seq_err),
      .alarm  (alarm),
      .fault  (fault)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: "started" means a first sample has been seen since clear.
   bit m_started, m_faulted, m_seq, m_alarm;
   int m_last, m_samples, m_wraps, m_errs;
   bit m_sv;
   int m_s_last, m_s_samples, m_s_wraps, m_s_errs;

   function automatic int sat(input int v, input int maxv);
      return (v + 1 > maxv) ? maxv : v + 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want)
      else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic model_clear();
      m_started = 0; m_faulted = 0; m_seq = 0; m_alarm = 0;
      m_last = 0; m_samples = 0; m_wraps = 0; m_errs = 0;
   endtask

   task automatic model_step();
      int v;
      v = int'(bus.t_out);
      if (rst) begin
         model_clear();
         m_sv = 0; m_s_last = 0; m_s_samples = 0; m_s_wraps = 0; m_s_errs = 0;
         return;
      end
      if (m_sv && bus.snap_ready) m_sv = 0;
      else if (!m_sv && bus.snap_req) begin
         m_sv = 1;
         m_s_last = m_last; m_s_samples = m_samples;
         m_s_wraps = m_wraps; m_s_errs = m_errs;
      end
      if (clr) model_clear();
      else if (bus.t_valid) begin
         if (m_faulted) m_samples = sat(m_samples, 65535);
         else begin
            if (!m_started) begin
               m_started = 1;
               m_samples = 1;
            end else begin
               m_samples = sat(m_samples, 65535);
               if (v == (m_last + 1) % 65536) begin
                  if (v == 0) m_wraps = sat(m_wraps, 255);
               end else begin
                  m_errs = sat(m_errs, 255);
                  m_seq = 1;
                  if (m_errs >= 4) m_faulted = 1;
               end
            end
            m_last = v;
            if (thresh != 0 && v >= int'(thresh)) m_alarm = 1;
         end
      end
   endtask

   task automatic check_all();
      chk("snap_valid",   32'(bus.snap_valid),   32'(m_sv));
      chk("snap_last",    32'(bus.snap_last),    32'(m_s_last));
      chk("snap_samples", 32'(bus.snap_samples), 32'(m_s_samples));
      chk("snap_wraps",   32'(bus.snap_wraps),   32'(m_s_wraps));
      chk("snap_errs",    32'(bus.snap_errs),    32'(m_s_errs));
      chk("seq_err",      32'(seq_err),          32'(m_seq));
      chk("alarm",        32'(alarm),            32'(m_alarm));
      chk("fault",        32'(fault),            32'(m_faulted));
   endtask

   // One clock: inputs are already set; model advances at the edge, outputs checked 1ns later.
   task automatic tick(input bit v, input logic [15:0] d);
      bus.t_valid = v;
      bus.t_out   = d;
      @(posedge clk);
      model_step();
      #1;
      check_all();
      bus.snap_req = 1'b0;
      clr          = 1'b0;
   endtask

   task automatic snap_read();
      bus.snap_req = 1'b1;
      tick(0, 16'h0);
   endtask

   task automatic snap_accept();
      bus.snap_ready = 1'b1;
      tick(0, 16'h0);
      bus.snap_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] drv;
      rst = 1'b1; clr = 1'b0; thresh = 16'h0;
      bus.t_valid = 1'b0; bus.t_out = 16'h0;
      bus.snap_req = 1'b0; bus.snap_ready = 1'b0;
      tick(0, 16'h0);
      tick(0, 16'h0);
      rst = 1'b0;
      chk("reset_fault", 32'(fault), 32'd0);

      // Basic run 5..14
      for (int i = 5; i <= 14; i++) tick(1, 16'(i));
      snap_read();
      chk("run_valid",   32'(bus.snap_valid),   32'd1);
      chk("run_samples", 32'(bus.snap_samples), 32'd10);
      chk("run_errs",    32'(bus.snap_errs),    32'd0);
      chk("run_last",    32'(bus.snap_last),    32'd14);
      chk("run_seq",     32'(seq_err),          32'd0);
      snap_accept();
      chk("run_accept",  32'(bus.snap_valid),   32'd0);

      // Gap cycles change nothing; 15 continues the sequence
      tick(0, 16'd99); tick(0, 16'd3); tick(1, 16'd15);
      chk("gap_seq", 32'(seq_err), 32'd0);

      // Wrap through 0xFFFF
      clr = 1'b1; tick(0, 16'h0);
      tick(1, 16'hFFFE); tick(1, 16'hFFFF); tick(1, 16'h0000); tick(1, 16'h0001);
      snap_read();
      chk("wrap_wraps", 32'(bus.snap_wraps), 32'd1);
      chk("wrap_errs",  32'(bus.snap_errs),  32'd0);
      chk("wrap_seq",   32'(seq_err),        32'd0);
      snap_accept();

      // Sequence error, resync, then fault
      clr = 1'b1; tick(0, 16'h0);
      tick(1, 16'd3); tick(1, 16'd4);
      chk("pre_err_seq", 32'(seq_err), 32'd0);
      tick(1, 16'd9);
      chk("err_seq", 32'(seq_err), 32'd1);
      tick(1, 16'd10);
      snap_read();
      chk("err_count", 32'(bus.snap_errs), 32'd1);
      snap_accept();
      tick(1, 16'd20); tick(1, 16'd30);
      chk("pre_fault", 32'(fault), 32'd0);
      tick(1, 16'd40);
      chk("fault_on", 32'(fault), 32'd1);
      tick(1, 16'd50); tick(1, 16'd60); tick(1, 16'd61);
      snap_read();
      chk("fault_errs",    32'(bus.snap_errs),    32'd4);
      chk("fault_samples", 32'(bus.snap_samples), 32'd10);
      snap_accept();

      // clr wins over a same-cycle sample while faulted
      clr = 1'b1; tick(1, 16'd7);
      chk("clr_fault", 32'(fault),   32'd0);
      chk("clr_seq",   32'(seq_err), 32'd0);
      tick(1, 16'd8);
      snap_read();
      chk("clr_samples", 32'(bus.snap_samples), 32'd1);
      chk("clr_last",    32'(bus.snap_last),    32'd8);
      chk("clr_errs",    32'(bus.snap_errs),    32'd0);
      snap_accept();

      // Alarm threshold
      clr = 1'b1; thresh = 16'd100; tick(0, 16'h0);
      tick(1, 16'd98); tick(1, 16'd99);
      chk("alarm_low", 32'(alarm), 32'd0);
      tick(1, 16'd100);
      chk("alarm_hit", 32'(alarm), 32'd1);
      tick(1, 16'd101); tick(0, 16'd0);
      chk("alarm_sticky", 32'(alarm), 32'd1);
      clr = 1'b1; thresh = 16'd0; tick(0, 16'h0);
      for (int i = 0; i < 4; i++) tick(1, 16'(60000 + i));
      chk("alarm_disabled", 32'(alarm), 32'd0);

      // Snapshot held while samples keep coming; second request ignored
      bus.snap_req = 1'b1; tick(1, 16'd60004);
      chk("hold_valid", 32'(bus.snap_valid), 32'd1);
      for (int i = 5; i < 10; i++) begin
         if (i == 7) bus.snap_req = 1'b1;
         tick(1, 16'(60000 + i));
      end
      chk("hold_samples", 32'(bus.snap_samples), 32'd4);
      clr = 1'b1; tick(0, 16'h0);
      chk("hold_after_clr", 32'(bus.snap_valid), 32'd1);
      bus.snap_req = 1'b1; snap_accept();
      chk("accept_drop", 32'(bus.snap_valid), 32'd0);
      tick(0, 16'h0);
      chk("req_on_accept_ignored", 32'(bus.snap_valid), 32'd0);

      // Random traffic against the model
      drv = 16'hFFF0;
      for (int c = 0; c < 1500; c++) begin
         bit v;
         v = ($urandom_range(0, 3) != 0);
         if (v) begin
            if ($urandom_range(0, 24) == 0) drv = 16'($urandom);
            else drv = drv + 16'd1;
         end
         if ($urandom_range(0, 199) == 0) clr = 1'b1;
         if ($urandom_range(0, 99) == 0)
            thresh = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'h0;
         bus.snap_req   = ($urandom_range(0, 7) == 0);
         bus.snap_ready = ($urandom_range(0, 2) == 0);
         tick(v, drv);
      end
      bus.snap_ready = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
